// File: rtl/arb_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD0 = 2'd1,
    HOLD1 = 2'd2
  } arb_state_t;

  localparam logic SRC0 = 1'b0;
  localparam logic SRC1 = 1'b1;

  // One-hot grant from the two valids. tie_src picks the winner when both are up.
  function automatic logic [1:0] rr_pick(input logic [1:0] v, input logic tie_src);
    logic [1:0] g;
    g = 2'b00;
    case (v)
      2'b01:   g = 2'b01;
      2'b10:   g = 2'b10;
      2'b11:   g = tie_src ? 2'b10 : 2'b01;
      default: g = 2'b00;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/arb2_rr_ctrl_mux2.sv
// 2:1 data bus mux (mux2) used to steer the granted payload into the output stage.
module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y
);

  assign y = s ? d1 : d0;

endmodule

// File: rtl/arb2_rr_ctrl.sv
// Two-requester round-robin arbiter feeding one registered output stage.
// Optional macro ARB_BURST_EN: on ties, let a requester keep winning for up
// to MAX_BURST consecutive grants before handing over.
module arb2_rr_ctrl
  import arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             mux_sel
);

  if (MAX_BURST < 2) begin : g_bad_burst
    $error("arb2_rr_ctrl: MAX_BURST must be at least 2");
  end

  arb_state_t       state;
  logic             last_src;
  logic             mux_sel_q;
  logic             can_accept;
  logic             tie_src;
  logic [1:0]       grant;
  logic             any_grant;
  logic             gnt_src;
  logic [WIDTH-1:0] mux_data;

  // state mirrors out_valid, so IDLE means the output register is free
  assign can_accept = (state == IDLE) || out_ready;

`ifdef ARB_BURST_EN
  localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURST - 1);

  logic [BW-1:0] burst_cnt;
  logic          streak;  // a grant has happened since reset, so last_src is real

  // stay with the current winner until its streak reaches the limit
  assign tie_src = (streak && (burst_cnt < BURST_LIM)) ? last_src : !last_src;

  // streak counter: same-source grants count up (saturating), a switch clears it
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      burst_cnt <= '0;
      streak    <= 1'b0;
    end else if (any_grant) begin
      streak <= 1'b1;
      if (streak && (gnt_src == last_src)) begin
        if (burst_cnt != BURST_LIM) burst_cnt <= burst_cnt + 1'b1;
      end else begin
        burst_cnt <= '0;
      end
    end
  end
`else
  assign tie_src = !last_src;
`endif

  // grant only when the output stage can take a beat and we are out of reset
  always_comb begin
    grant = 2'b00;
    if (reset_n && can_accept) grant = rr_pick({req1_valid, req0_valid}, tie_src);
  end

  assign any_grant  = |grant;
  assign gnt_src    = grant[1];
  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  // hold the last select on idle cycles so the mux does not toggle needlessly
  assign mux_sel = any_grant ? gnt_src : mux_sel_q;

  mux2 #(.WIDTH(WIDTH)) u_mux (
    .d0 (req0_data),
    .d1 (req1_data),
    .s  (mux_sel),
    .y  (mux_data)
  );

  // output stage + FSM: refill on grant (drain and refill in one edge), else drain
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= SRC0;
      last_src  <= SRC1;
      mux_sel_q <= 1'b0;
      state     <= IDLE;
    end else if (any_grant) begin
      out_valid <= 1'b1;
      out_data  <= mux_data;
      out_src   <= gnt_src;
      last_src  <= gnt_src;
      mux_sel_q <= gnt_src;
      state     <= gnt_src ? HOLD1 : HOLD0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

endmodule
